// File: rtl/expr_sched.sv
// Arbitrates two byte-stream requesters onto one shared expression matcher:
// grants per expression, clears the matcher, forwards bytes and reports a tagged result.
module expr_sched #(
  parameter logic [7:0] TERM      = 8'h3B,
  parameter int         MAX_LEN   = 255,
  parameter int         MATCH_LAT = 1
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       m_clr,
  output logic       m_en,
  output logic [7:0] m_in,
  input  logic       m_out,
  output logic       res_valid,
  output logic       res_id,
  output logic       res_match,
  output logic       res_ovf,
  output logic       busy,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_FEED, S_DRAIN, S_WAIT, S_REPORT
  } state_t;

  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [2:0] LAT_LAST  = 3'(MATCH_LAT - 1);

  state_t     r_state, w_next;
  logic       r_gnt, r_last_grant, r_ovf, r_m_en;
  logic [7:0] r_m_in, r_len;
  logic [2:0] r_cnt;
  logic       r_res_id, r_res_match, r_res_ovf;
  logic       w_take, w_valid, w_hs, w_is_term, w_gnt_next;
  logic [7:0] w_data;

  // Handshake: a byte moves at a rising edge where valid && ready are both high.
  // Ready depends only on registered state, never on the requester's valid.
  assign w_take     = (r_state == S_FEED) || (r_state == S_DRAIN);
  assign req0_ready = w_take && !r_gnt;
  assign req1_ready = w_take && r_gnt;
  assign w_valid    = r_gnt ? req1_valid : req0_valid;
  assign w_data     = r_gnt ? req1_data : req0_data;
  assign w_hs       = w_take && w_valid;
  assign w_is_term  = (w_data == TERM);
  assign w_gnt_next = (req0_valid && req1_valid) ? !r_last_grant : req1_valid;

  assign m_clr     = (r_state == S_CLEAR);
  assign busy      = (r_state != S_IDLE);
  assign res_valid = (r_state == S_REPORT);
  assign m_en      = r_m_en;
  assign m_in      = r_m_in;
  assign res_id    = r_res_id;
  assign res_match = r_res_match;
  assign res_ovf   = r_res_ovf;
  assign dbg_state = r_state;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (req0_valid || req1_valid) w_next = S_CLEAR;
      S_CLEAR:  w_next = S_FEED;
      S_FEED: begin
        if (w_hs && w_is_term)                 w_next = S_WAIT;
        else if (w_hs && (r_len >= MAX_LEN_B)) w_next = S_DRAIN;
      end
      S_DRAIN:  if (w_hs && w_is_term) w_next = S_WAIT;
      S_WAIT:   if (r_cnt == LAT_LAST) w_next = S_REPORT;
      S_REPORT: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_gnt        <= 1'b0;
      r_last_grant <= 1'b1;
      r_ovf        <= 1'b0;
      r_m_en       <= 1'b0;
      r_m_in       <= 8'h00;
      r_len        <= 8'h00;
      r_cnt        <= 3'd0;
      r_res_id     <= 1'b0;
      r_res_match  <= 1'b0;
      r_res_ovf    <= 1'b0;
    end else begin
      r_m_en <= 1'b0;
      case (r_state)
        S_IDLE: if (req0_valid || req1_valid) r_gnt <= w_gnt_next;
        S_CLEAR: begin
          r_len <= 8'h00;
          r_ovf <= 1'b0;
          r_cnt <= 3'd0;
        end
        S_FEED: begin
          if (w_hs && !w_is_term) begin
            if (r_len < MAX_LEN_B) begin
              r_m_en <= 1'b1;
              r_m_in <= w_data;
              r_len  <= r_len + 8'd1;
            end else begin
              r_ovf <= 1'b1;
            end
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt + 3'd1;
          // An empty or overflowed expression never matches, whatever the matcher says.
          if (r_cnt == LAT_LAST) begin
            r_res_id    <= r_gnt;
            r_res_match <= m_out && !r_ovf && (r_len != 8'h00);
            r_res_ovf   <= r_ovf;
          end
        end
        S_REPORT: r_last_grant <= r_gnt;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_expr_sched.sv
// Directed bench for expr_sched: stand-in matcher, whole-expression result model,
// per-cycle compare process and literal expectations per scenario.
module tb_expr_sched;

  localparam logic [7:0] TERM      = 8'h3B;
  localparam int         MAX_LEN   = 5;
  localparam int         MATCH_LAT = 1;

  typedef logic [7:0] bq_t[$];

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic [7:0] req0_data = 8'h00, req1_data = 8'h00;
  logic       req0_ready, req1_ready;
  logic       m_clr, m_en, m_out;
  logic [7:0] m_in;
  logic       res_valid, res_id, res_match, res_ovf, busy;
  logic [2:0] dbg_state;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  expr_sched #(.TERM(TERM), .MAX_LEN(MAX_LEN), .MATCH_LAT(MATCH_LAT)) dut (
    .clk(clk), .clr(clr),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .m_clr(m_clr), .m_en(m_en), .m_in(m_in), .m_out(m_out),
    .res_valid(res_valid), .res_id(res_id), .res_match(res_match), .res_ovf(res_ovf),
    .busy(busy), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- helpers ----------------
  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
    end
  endfunction

  function automatic bit is_digit(input logic [7:0] c);
    return (c >= 8'h30) && (c <= 8'h39);
  endfunction

  function automatic bit is_op(input logic [7:0] c);
    return (c == 8'h2B) || (c == 8'h2D) || (c == 8'h2A) || (c == 8'h2F);
  endfunction

  function automatic bq_t to_q(input string s);
    bq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  // Whole-string rule: digit runs separated by single operators, non-empty.
  function automatic bit expr_ok(input bq_t s);
    bit prev_digit;
    prev_digit = 1'b0;
    if (s.size() == 0) return 1'b0;
    foreach (s[i]) begin
      if (is_digit(s[i]))                 prev_digit = 1'b1;
      else if (is_op(s[i]) && prev_digit) prev_digit = 1'b0;
      else                                return 1'b0;
    end
    return prev_digit;
  endfunction

  // ---------------- stand-in matcher (1-cycle latency) ----------------
  logic [1:0] mt_st = 2'd0;   // 0 expect operand, 1 after digit, 2 error
  always @(posedge clk) begin
    if (m_clr) mt_st <= 2'd0;
    else if (m_en) begin
      if (mt_st == 2'd2)     mt_st <= 2'd2;
      else if (is_digit(m_in)) mt_st <= 2'd1;
      else if (is_op(m_in) && mt_st == 2'd1) mt_st <= 2'd0;
      else                   mt_st <= 2'd2;
    end
  end
  assign m_out = (mt_st == 2'd1);

  // ---------------- model + scoreboard ----------------
  logic [34:0] exp_q[$];       // {due_cycle, id, match, ovf}
  bq_t         acc0, acc1;
  logic        pend_en = 1'b0;
  logic [7:0]  pend_byte = 8'h00;
  logic [7:0]  last_fwd = 8'h00;
  int          clr_seen = 0;
  int          clr_total = 0;
  int          men_count = 0;
  logic [2:0]  res_log[$];
  logic [7:0]  fwd_log[$];

  function automatic void model_byte(input bit id, input logic [7:0] d);
    bq_t s;
    bit  ovf, match;
    s = id ? acc1 : acc0;
    if (d == TERM) begin
      ovf   = (s.size() > MAX_LEN);
      match = !ovf && expr_ok(s);
      exp_q.push_back({32'(cyc + 1 + MATCH_LAT), id, match, ovf});
      s.delete();
    end else begin
      if (s.size() < MAX_LEN) begin
        pend_en   = 1'b1;
        pend_byte = d;
      end
      s.push_back(d);
    end
    if (id) acc1 = s;
    else    acc0 = s;
  endfunction

  always @(negedge clk) begin
    bit exp_now;
    if (!clr) begin
      exp_q.delete();
      acc0.delete();
      acc1.delete();
      pend_en  = 1'b0;
      last_fwd = 8'h00;
      clr_seen = 0;
      check("reset_outputs",
            64'({req0_ready, req1_ready, m_clr, m_en, m_in, res_valid, res_id, res_match, res_ovf, busy}),
            64'(0));
    end else begin
      check("m_en", 64'(m_en), 64'(pend_en));
      if (pend_en) last_fwd = pend_byte;
      check("m_in", 64'(m_in), 64'(last_fwd));
      if (m_en) begin
        fwd_log.push_back(m_in);
        men_count++;
      end
      if (m_clr) begin
        clr_seen++;
        clr_total++;
      end
      check("ready_exclusive", 64'(req0_ready && req1_ready), 64'(0));
      if (req0_ready || req1_ready || m_clr || res_valid) check("busy", 64'(busy), 64'(1));
      exp_now = (exp_q.size() != 0) && (int'(exp_q[0][34:3]) == cyc);
      check("res_valid", 64'(res_valid), 64'(exp_now));
      if (res_valid && exp_now) begin
        check("res_fields", 64'({res_id, res_match, res_ovf}), 64'(exp_q[0][2:0]));
        check("m_clr_per_expr", 64'(clr_seen), 64'(1));
      end
      if (res_valid) begin
        res_log.push_back({res_id, res_match, res_ovf});
        clr_seen = 0;
      end
      if (exp_q.size() != 0 && int'(exp_q[0][34:3]) <= cyc) void'(exp_q.pop_front());
      pend_en = 1'b0;
      if (req0_valid && req0_ready) model_byte(1'b0, req0_data);
      if (req1_valid && req1_ready) model_byte(1'b1, req1_data);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_req(input bit id, input logic v, input logic [7:0] d);
    if (id) begin req1_valid = v; req1_data = d; end
    else    begin req0_valid = v; req0_data = d; end
  endtask

  task automatic wait_accept(input bit id);
    int n;
    bit acc;
    n   = 0;
    acc = 1'b0;
    while (!acc) begin
      @(negedge clk);
      acc = id ? (req1_ready && req1_valid) : (req0_ready && req0_valid);
      @(posedge clk);
      #1;
      n++;
      if (!acc && n > 300) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout id=%0d: got no ready in 300 cycles, required ready", id);
        return;
      end
    end
  endtask

  task automatic send(input bit id, input string s, input int stall_at, input int stall_n);
    for (int i = 0; i < s.len(); i++) begin
      set_req(id, 1'b1, s[i]);
      wait_accept(id);
      if (i == stall_at) begin
        set_req(id, 1'b0, 8'h00);
        repeat (stall_n) @(posedge clk);
        #1;
      end
    end
    set_req(id, 1'b0, 8'h00);
  endtask

  task automatic wait_results(input int k);
    int n;
    n = 0;
    while (res_log.size() < k && n < 500) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (res_log.size() < k) begin
      errors++;
      $display("FAIL result_timeout: got %0d results, required %0d", res_log.size(), k);
    end
    @(negedge clk);
  endtask

  task automatic clear_logs();
    res_log.delete();
    fwd_log.delete();
    men_count = 0;
  endtask

  function automatic logic [39:0] pack5();
    logic [39:0] p;
    p = '0;
    for (int i = 0; i < 5; i++) p = {p[31:0], (i < fwd_log.size()) ? fwd_log[i] : 8'h00};
    return p;
  endfunction

  // ---------------- directed scenarios ----------------
  initial begin
    int n;
    int clr_before;

    check("pin_expr_ok_valid",  64'(expr_ok(to_q("1+2*3"))), 64'(1));
    check("pin_expr_ok_double", 64'(expr_ok(to_q("1++2"))),  64'(0));
    check("pin_expr_ok_empty",  64'(expr_ok(to_q(""))),      64'(0));
    check("pin_expr_ok_trail",  64'(expr_ok(to_q("12+"))),   64'(0));

    // Reset with both requesters asking for a bare terminator.
    #1 clr = 1'b0;
    req0_valid = 1'b1; req0_data = TERM;
    req1_valid = 1'b1; req1_data = TERM;
    repeat (3) @(posedge clk);
    #1 clr = 1'b1;
    // Release lands just after an edge: IDLE sees valid at the next edge, FEED one later.
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(req0_ready || req1_ready) && n < 20);
    check("first_ready_latency", 64'(n), 64'(3));
    check("first_grant", 64'({req0_ready, req1_ready}), 64'(2'b10));
    check("first_m_clr_count", 64'(clr_total), 64'(1));
    @(posedge clk);
    #1 req0_valid = 1'b0;
    wait_accept(1'b1);
    req1_valid = 1'b0;
    wait_results(2);
    check("empty_expr_results", 64'({res_log[0], res_log[1]}), 64'(6'b000_100));
    check("empty_expr_no_m_en", 64'(men_count), 64'(0));

    clear_logs();
    send(1'b0, "1+2*3;", -1, 0);
    wait_results(1);
    check("expr1_m_en_pulses", 64'(men_count), 64'(5));
    check("expr1_bytes", 64'(pack5()), 64'(40'h31_2B_32_2A_33));
    check("expr1_result", 64'(res_log[0]), 64'(3'b010));

    clear_logs();
    send(1'b1, "1++2;", 1, 3);
    wait_results(1);
    check("stall_m_en_pulses", 64'(men_count), 64'(4));
    check("stall_result", 64'(res_log[0]), 64'(3'b100));

    clear_logs();
    fork
      begin send(1'b0, "4*9;", -1, 0); send(1'b0, "4*9;", -1, 0); end
      begin send(1'b1, "4*9;", -1, 0); send(1'b1, "4*9;", -1, 0); end
    join
    wait_results(4);
    check("alternation", 64'({res_log[0], res_log[1], res_log[2], res_log[3]}),
          64'(12'b010_110_010_110));

    clear_logs();
    send(1'b1, "123456+6;", -1, 0);
    wait_results(1);
    check("ovf_m_en_pulses", 64'(men_count), 64'(MAX_LEN));
    check("ovf_bytes", 64'(pack5()), 64'(40'h31_32_33_34_35));
    check("ovf_result", 64'(res_log[0]), 64'(3'b101));

    clear_logs();
    send(1'b0, "12+45;", -1, 0);
    wait_results(1);
    check("exact_max_len_result", 64'(res_log[0]), 64'(3'b010));
    check("exact_max_len_pulses", 64'(men_count), 64'(5));

    // Abort an expression mid-FEED with an asynchronous reset.
    clear_logs();
    set_req(1'b0, 1'b1, 8'h37);
    wait_accept(1'b0);
    set_req(1'b0, 1'b0, 8'h00);
    #1 clr = 1'b0;
    #1 check("abort_outputs_drop",
             64'({req0_ready, req1_ready, busy, m_en, m_clr, res_valid}), 64'(0));
    repeat (2) @(posedge clk);
    #1 clr = 1'b1;
    repeat (5) @(posedge clk);
    check("abort_no_result", 64'(res_log.size()), 64'(0));
    clr_before = clr_total;
    send(1'b0, "5*5;", -1, 0);
    wait_results(1);
    check("after_abort_result", 64'(res_log[0]), 64'(3'b010));
    check("after_abort_fresh_clr", 64'(clr_total - clr_before), 64'(1));

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1);
  end

endmodule
